// File: rtl/opal_tx_pkg.sv
// ----------------------------------------------------------------------------
// opal_tx_pkg : shared types and constants for the OPAL transmit scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package opal_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLOTS = 2'd1,
    ST_CHECK = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

  // Slot-index width; kept at least one bit so a single-slot build still has an index.
  function automatic int slot_idx_w(input int n_slots);
    return (n_slots > 1) ? $clog2(n_slots) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/opal_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// opal_tx_scheduler_if : configuration, slot data and byte-link bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface opal_tx_scheduler_if #(
  parameter int N_SLOTS  = 16,
  parameter int PERIOD_W = 16
);

  logic                   i_tick;
  logic                   cfg_enable;
  logic [N_SLOTS-1:0]     cfg_slot_mask;
  logic [PERIOD_W-1:0]    cfg_period;
  logic [8*N_SLOTS-1:0]   i_slot_data;
  logic [7:0]             o_data_tx;
  logic                   o_tx_valid;
  logic                   o_frame_start;
  logic                   o_busy;
  logic [15:0]            o_frame_count;

  modport master (
    output i_tick, cfg_enable, cfg_slot_mask, cfg_period, i_slot_data,
    input  o_data_tx, o_tx_valid, o_frame_start, o_busy, o_frame_count
  );

  modport slave (
    input  i_tick, cfg_enable, cfg_slot_mask, cfg_period, i_slot_data,
    output o_data_tx, o_tx_valid, o_frame_start, o_busy, o_frame_count
  );

endinterface

`default_nettype wire

// File: rtl/opal_slot_picker.sv
// ----------------------------------------------------------------------------
// opal_slot_picker : finds the lowest set mask bit strictly above an index
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module opal_slot_picker
  import opal_tx_pkg::*;
#(
  parameter int N_SLOTS = 16,
  parameter int IDX_W   = slot_idx_w(N_SLOTS)
) (
  input  logic [N_SLOTS-1:0]   i_mask,
  input  logic signed [IDX_W:0] i_cur_idx,
  output logic [IDX_W-1:0]     o_next_idx,
  output logic                 o_found
);

  // Scanning downward leaves the lowest qualifying slot as the final winner.
  always_comb begin
    o_next_idx = '0;
    o_found    = 1'b0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (i_mask[k] && (k > int'(i_cur_idx))) begin
        o_next_idx = IDX_W'(k);
        o_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/opal_tx_scheduler.sv
// ----------------------------------------------------------------------------
// opal_tx_scheduler : emits header, enabled slot bytes and XOR checksum per frame
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module opal_tx_scheduler
  import opal_tx_pkg::*;
#(
  parameter int         N_SLOTS     = 16,
  parameter int         PERIOD_W    = 16,
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT
) (
  input  logic               CLK100MHz,
  input  logic               ARESETN,
  opal_tx_scheduler_if.slave bus
);

  localparam int IDX_W = slot_idx_w(N_SLOTS);

  state_t                 state_q, state_d;
  logic [PERIOD_W-1:0]    gap_q, gap_d;
  logic [7:0]             csum_q, csum_d;
  logic [8*N_SLOTS-1:0]   shadow_data_q, shadow_data_d;
  logic [N_SLOTS-1:0]     shadow_mask_q, shadow_mask_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             data_tx_q, data_tx_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   frame_start_q, frame_start_d;
  logic                   busy_q, busy_d;
  logic [15:0]            frame_count_q, frame_count_d;

  logic [N_SLOTS-1:0]     pick_mask;
  logic signed [IDX_W:0]  pick_cur;
  logic [IDX_W-1:0]       pick_next;
  logic                   pick_found;
  logic [7:0]             slot_byte;

  assign slot_byte = shadow_data_q[{idx_q, 3'b000} +: 8];

  // In IDLE the live mask is searched from index -1 to find the first slot of the
  // upcoming frame; afterwards the shadow mask is walked from the current slot.
  always_comb begin
    if (state_q == ST_IDLE) begin
      pick_mask = bus.cfg_slot_mask;
      pick_cur  = '1;
    end else begin
      pick_mask = shadow_mask_q;
      pick_cur  = {1'b0, idx_q};
    end
  end

  opal_slot_picker #(
    .N_SLOTS (N_SLOTS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_mask     (pick_mask),
    .i_cur_idx  (pick_cur),
    .o_next_idx (pick_next),
    .o_found    (pick_found)
  );

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    csum_d        = csum_q;
    shadow_data_d = shadow_data_q;
    shadow_mask_d = shadow_mask_q;
    idx_d         = idx_q;
    data_tx_d     = data_tx_q;
    tx_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;

    if (bus.i_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_enable) begin
            data_tx_d     = HEADER_BYTE;
            tx_valid_d    = 1'b1;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
            csum_d        = HEADER_BYTE;
            shadow_data_d = bus.i_slot_data;
            shadow_mask_d = bus.cfg_slot_mask;
            idx_d         = pick_next;
            state_d       = pick_found ? ST_SLOTS : ST_CHECK;
          end
        end
        ST_SLOTS: begin
          data_tx_d  = slot_byte;
          tx_valid_d = 1'b1;
          csum_d     = csum_q ^ slot_byte;
          idx_d      = pick_next;
          if (!pick_found) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          data_tx_d     = csum_q;
          tx_valid_d    = 1'b1;
          busy_d        = 1'b0;
          frame_count_d = frame_count_q + 16'd1;
          if (bus.cfg_period == '0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d   = bus.cfg_period;
            state_d = ST_GAP;
          end
        end
        ST_GAP: begin
          gap_d = gap_q - 1'b1;
          if (gap_d == '0) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHz) begin
    if (!ARESETN) begin
      state_q       <= ST_IDLE;
      gap_q         <= '0;
      csum_q        <= '0;
      shadow_data_q <= '0;
      shadow_mask_q <= '0;
      idx_q         <= '0;
      data_tx_q     <= '0;
      tx_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      csum_q        <= csum_d;
      shadow_data_q <= shadow_data_d;
      shadow_mask_q <= shadow_mask_d;
      idx_q         <= idx_d;
      data_tx_q     <= data_tx_d;
      tx_valid_q    <= tx_valid_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.o_data_tx     = data_tx_q;
  assign bus.o_tx_valid    = tx_valid_q;
  assign bus.o_frame_start = frame_start_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_opal_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_opal_tx_scheduler : directed self-checking bench for opal_tx_scheduler
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_opal_tx_scheduler;

  localparam int N = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  opal_tx_scheduler_if #(.N_SLOTS(N), .PERIOD_W(16)) bus ();

  opal_tx_scheduler #(
    .N_SLOTS     (N),
    .PERIOD_W    (16),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .CLK100MHz (clk),
    .ARESETN   (rst_n),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds i_tick for one cycle and returns at the next negedge.
  task automatic tick();
    bus.i_tick = 1'b1;
    @(negedge clk);
    bus.i_tick = 1'b0;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] b,
                             input logic start, input logic busy);
    tick();
    check({tag, " valid"}, bus.o_tx_valid, 1);
    check({tag, " data"},  bus.o_data_tx, b);
    check({tag, " start"}, bus.o_frame_start, start);
    check({tag, " busy"},  bus.o_busy, busy);
  endtask

  task automatic expect_silent(input string tag);
    tick();
    check({tag, " valid"}, bus.o_tx_valid, 0);
  endtask

  // Reference frame: header, set slots ascending, XOR of everything sent.
  task automatic expect_frame(input string tag, input logic [N-1:0] m,
                              input logic [8*N-1:0] d, input logic [15:0] cnt_after);
    logic [7:0] cs;
    cs = 8'hA5;
    expect_byte({tag, " hdr"}, 8'hA5, 1'b1, 1'b1);
    for (int k = 0; k < N; k++) begin
      if (m[k]) begin
        expect_byte($sformatf("%s s%0d", tag, k), d[8*k +: 8], 1'b0, 1'b1);
        cs = cs ^ d[8*k +: 8];
      end
    end
    expect_byte({tag, " csum"}, cs, 1'b0, 1'b0);
    check({tag, " count"}, bus.o_frame_count, cnt_after);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_tick        = 1'b0;
    bus.cfg_enable    = 1'b0;
    bus.cfg_slot_mask = '0;
    bus.cfg_period    = '0;
    for (int k = 0; k < N; k++) bus.i_slot_data[8*k +: 8] = 8'h40 + 8'(k);
    bus.i_slot_data[7:0]   = 8'h11;
    bus.i_slot_data[15:8]  = 8'h33;
    bus.i_slot_data[23:16] = 8'h22;

    repeat (3) @(negedge clk);
    check("rst data",  bus.o_data_tx, 0);
    check("rst valid", bus.o_tx_valid, 0);
    check("rst start", bus.o_frame_start, 0);
    check("rst busy",  bus.o_busy, 0);
    check("rst count", bus.o_frame_count, 0);
    rst_n = 1'b1;

    // Two back-to-back frames over slots 0 and 2, slot 1 skipped.
    bus.cfg_slot_mask = 16'h0005;
    bus.cfg_enable    = 1'b1;
    @(negedge clk);
    expect_byte("A1 hdr",  8'hA5, 1'b1, 1'b1);
    expect_byte("A1 s0",   8'h11, 1'b0, 1'b1);
    expect_byte("A1 s2",   8'h22, 1'b0, 1'b1);
    expect_byte("A1 csum", 8'h96, 1'b0, 1'b0);
    check("A1 count", bus.o_frame_count, 1);
    expect_byte("A2 hdr",  8'hA5, 1'b1, 1'b1);
    expect_byte("A2 s0",   8'h11, 1'b0, 1'b1);
    expect_byte("A2 s2",   8'h22, 1'b0, 1'b1);
    expect_byte("A2 csum", 8'h96, 1'b0, 1'b0);
    check("A2 count", bus.o_frame_count, 2);
    @(negedge clk);
    check("A hold valid", bus.o_tx_valid, 0);
    check("A hold data",  bus.o_data_tx, 8'h96);

    // Empty mask: header followed directly by checksum equal to the header.
    bus.cfg_slot_mask = 16'h0000;
    expect_byte("B1 hdr",  8'hA5, 1'b1, 1'b1);
    expect_byte("B1 csum", 8'hA5, 1'b0, 1'b0);
    expect_byte("B2 hdr",  8'hA5, 1'b1, 1'b1);
    expect_byte("B2 csum", 8'hA5, 1'b0, 1'b0);
    check("B count", bus.o_frame_count, 4);

    // Inter-frame gap of three ticks.
    bus.cfg_slot_mask = 16'h0005;
    bus.cfg_period    = 16'd3;
    expect_byte("C1 hdr",  8'hA5, 1'b1, 1'b1);
    expect_byte("C1 s0",   8'h11, 1'b0, 1'b1);
    expect_byte("C1 s2",   8'h22, 1'b0, 1'b1);
    expect_byte("C1 csum", 8'h96, 1'b0, 1'b0);
    expect_silent("C gap1");
    expect_silent("C gap2");
    expect_silent("C gap3");
    expect_byte("C2 hdr",  8'hA5, 1'b1, 1'b1);
    expect_byte("C2 s0",   8'h11, 1'b0, 1'b1);
    expect_byte("C2 s2",   8'h22, 1'b0, 1'b1);
    expect_byte("C2 csum", 8'h96, 1'b0, 1'b0);
    check("C count", bus.o_frame_count, 6);
    expect_silent("C gap4");
    expect_silent("C gap5");
    bus.cfg_period = 16'd0;
    expect_silent("C gap6");

    // Mid-frame changes to data and mask must not disturb the frame in flight.
    expect_byte("D1 hdr", 8'hA5, 1'b1, 1'b1);
    expect_byte("D1 s0",  8'h11, 1'b0, 1'b1);
    bus.i_slot_data[7:0] = 8'h77;
    bus.cfg_slot_mask    = 16'hFFFF;
    expect_byte("D1 s2",   8'h22, 1'b0, 1'b1);
    expect_byte("D1 csum", 8'h96, 1'b0, 1'b0);
    check("D1 count", bus.o_frame_count, 7);
    expect_frame("D2", 16'hFFFF, bus.i_slot_data, 16'd8);

    // Reset in the middle of a frame, released with the scheduler disabled.
    bus.cfg_slot_mask    = 16'h0005;
    bus.i_slot_data[7:0] = 8'h11;
    expect_byte("E hdr", 8'hA5, 1'b1, 1'b1);
    expect_byte("E s0",  8'h11, 1'b0, 1'b1);
    rst_n          = 1'b0;
    bus.cfg_enable = 1'b0;
    tick();
    check("E rst data",  bus.o_data_tx, 0);
    check("E rst valid", bus.o_tx_valid, 0);
    check("E rst busy",  bus.o_busy, 0);
    check("E rst count", bus.o_frame_count, 0);
    rst_n = 1'b1;
    expect_silent("E off1");
    expect_silent("E off2");
    expect_silent("E off3");
    check("E off busy", bus.o_busy, 0);
    bus.cfg_enable = 1'b1;
    expect_byte("E2 hdr", 8'hA5, 1'b1, 1'b1);

    // Disable after the header, with the frame counter parked at its maximum.
    bus.cfg_enable = 1'b0;
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    check("F preload", bus.o_frame_count, 16'hFFFF);
    expect_byte("F s0",   8'h11, 1'b0, 1'b1);
    expect_byte("F s2",   8'h22, 1'b0, 1'b1);
    expect_byte("F csum", 8'h96, 1'b0, 1'b0);
    check("F wrap count", bus.o_frame_count, 0);
    expect_silent("F stop1");
    expect_silent("F stop2");
    expect_silent("F stop3");
    check("F stop busy", bus.o_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/opal_tx_scheduler.md
Name: opal_tx_scheduler

Overview:
- Frame scheduler that shares the single 8-bit OPAL transmit link between up to N_SLOTS byte variables written over AXI.
- On each OPAL tick it emits one byte of a frame: header byte, the enabled slot bytes in ascending slot order, then an XOR checksum.
- Idle ticks between frames are set by cfg_period.
- Sits between the AXI register file (slot data and configuration) and the byte link toward the OPAL simulator.

Parameters:
- N_SLOTS, 16, number of byte slots (1..16)
- PERIOD_W, 16, width of inter-frame gap counter
- HEADER_BYTE, 8'hA5, frame start marker

Ports:
- CLK100MHz  input  1  system clock
- ARESETN  input  1  synchronous active-low reset
- i_tick  input  1  one-cycle strobe per OPAL byte slot, already synchronised to CLK100MHz
- cfg_enable  input  1  1 = run frames; 0 = stop after the current frame
- cfg_slot_mask  input  N_SLOTS  bit k = 1 includes slot k
- cfg_period  input  PERIOD_W  idle ticks between the checksum byte and the next header
- i_slot_data  input  8*N_SLOTS  slot k at bits [8k+7:8k]
- o_data_tx  output  8  byte on the link
- o_tx_valid  output  1  one-cycle pulse; o_data_tx is new this cycle
- o_frame_start  output  1  one-cycle pulse together with the header byte
- o_busy  output  1  high from the header until the checksum is emitted
- o_frame_count  output  16  frames completed; wraps at 65535 -> 0

Behaviour:
- Reset (ARESETN=0 at a rising edge):
  - Outputs: o_data_tx=0, o_tx_valid=0, o_frame_start=0, o_busy=0, o_frame_count=0.
  - Internal state: state=IDLE, gap counter=0, checksum=0.
- Reset has priority over every other event, including mid-frame. A partial frame is abandoned and never resumed.
- All outputs are registered. A byte produced by the tick at cycle t appears with o_tx_valid=1 at cycle t+1. No output changes on cycles without a tick, except that o_tx_valid and o_frame_start drop after one cycle.
- States:
  - IDLE:
    - On a tick with cfg_enable=1: emit HEADER_BYTE and pulse o_frame_start.
    - In the same cycle, snapshot i_slot_data and cfg_slot_mask into shadow registers and set checksum=HEADER_BYTE.
    - Then go to SLOTS if the mask is non-zero, else to CHECK.
  - SLOTS:
    - Each tick emits the shadow byte of the current slot and XORs it into the checksum. Current slot = lowest set mask bit above the previously sent slot.
    - Masked-off slots consume no ticks.
    - After the highest set slot, go to CHECK.
  - CHECK:
    - On a tick, emit the checksum and increment o_frame_count.
    - If cfg_period=0, go to IDLE. Otherwise load the gap counter with cfg_period and go to GAP.
  - GAP: each tick decrements the counter; on reaching 0, go to IDLE. No bytes are emitted in GAP.
- o_busy=1 in SLOTS and CHECK, and in the cycle after the header is accepted. It clears on the cycle o_tx_valid shows the checksum.
- cfg_enable:
  - Sampled only in IDLE. Deasserting it mid-frame or in GAP lets the frame and gap finish, then the block holds in IDLE.
  - Asserting it in GAP does not shorten the gap.
- Changes to cfg_slot_mask or i_slot_data during a frame have no effect until the next header, because the shadow registers are used.
- i_tick held high for several cycles counts once per cycle; each high cycle is a tick.
- Frame length = popcount(mask) + 2 ticks. Period between headers = frame length + cfg_period ticks.

Decomposition:
- Shared package opal_tx_pkg:
  - state enum {IDLE, SLOTS, CHECK, GAP}
  - HEADER_BYTE default constant
  - slot-index width function clog2(N_SLOTS)
- One sub-module, opal_slot_picker: combinational "next set bit strictly above index". Inputs are mask and current index. Outputs are next index and a found flag. It is also used with index=-1 to find the first slot.

Test Plan:
- Reset mid-frame: assert ARESETN=0 during SLOTS, then release with cfg_enable=0 -> all outputs 0, o_frame_count=0, no o_tx_valid until the first tick after re-enable.
- mask=16'h0005, slot0=8'h11, slot2=8'h22, period=0, continuous ticks -> bytes A5,11,22,96 (A5^11^22), then A5 again on the next tick; o_frame_count increments once per frame.
- mask=0 -> frame is A5,A5 (checksum=header); o_frame_start pulses on every other tick.
- period=3 -> exactly 3 ticks with no o_tx_valid between a checksum and the next header.
- Change slot0 from 8'h11 to 8'h77 and mask to 16'hFFFF during SLOTS -> the current frame still sends 11,22 and checksum 96; the next frame uses the new values and all 16 slots.
- cfg_enable dropped after the header -> the frame completes with its checksum, then no further valid bytes; o_frame_count wraps from 16'hFFFF to 0 (preload via long run or forced start value).
